control_multiciclo: RTL and testbench
=====================================

# control_multiciclo

Multicycle main control FSM for the RISC-V core, the parametrised successor to the single-cycle decoder. It sequences each instruction over 3-5 states, with optional wait states for a memory that answers via a ready handshake. It adds I-type arithmetic and JAL support, a memory-timeout fault, and a retired-instruction counter. It sits between the IR opcode field and the shared-ALU/shared-memory datapath.

## Interface
- MEM_TIMEOUT, 16, maximum consecutive cycles a memory state waits for memReady; 0 disables the timeout.
- IMM_EN, 1, decode opcode 0010011 (I-type arith) when 1.
- JAL_EN, 1, decode opcode 1101111 (JAL) when 1.
- CNT_W, 32, width of retired-instruction counter.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- instruc  in  7  opcode from IR; stable from DECODE until the next FETCH.
- memReady  in  1  memory completes the current read/write this cycle.
- pcWrite, branch, irWrite, memRead, memWrite, iOrD, regWrite, aluSrcA  out  1 each  datapath strobes/selects.
- aluSrcB  out  2  00 rs2, 01 constant 4, 10 immediate.
- aluOp  out  2  00 add, 01 branch compare, 10 R-type funct, 11 I-type funct.
- regSrc  out  2  write-back source: 00 ALUOut, 01 memory data, 10 PC (link).
- pcSource  out  1  0 ALU result, 1 ALUOut.
- illegal  out  1  one-cycle pulse in DECODE for an unsupported opcode.
- fault  out  1  high while in FAULT.
- state  out  4  current state encoding (debug).
- instret  out  CNT_W  retired-instruction count.

## Operation
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JAL=9, FAULT=15.
- All outputs are 0 unless listed for a state.
- FETCH:
  - Outputs: memRead=1, aluSrcB=01, aluOp=00.
  - Qualified on memReady: irWrite=1, pcWrite=1, pcSource=0.
  - Stay while !memReady; on memReady go to DECODE.
- DECODE:
  - Outputs: aluSrcB=10, aluOp=00 (branch target into ALUOut).
  - 0000011 or 0100011 go to MEMADR.
  - 0110011 goes to EXEC.
  - 0010011 goes to EXEC if IMM_EN.
  - 1100011 goes to BRANCH.
  - 1101111 goes to JAL if JAL_EN.
  - Any other opcode: illegal=1, go to FETCH (executed as NOP, not counted).
- MEMADR: aluSrcA=1, aluSrcB=10, aluOp=00. Load goes to MEMRD, store goes to MEMWR.
- MEMRD: memRead=1, iOrD=1. Wait for memReady, then go to MEMWB.
- MEMWB: regWrite=1, regSrc=01. Go to FETCH.
- MEMWR: memWrite=1, iOrD=1. Wait for memReady, then go to FETCH.
- EXEC: aluSrcA=1.
  - R-type: aluSrcB=00, aluOp=10.
  - I-type: aluSrcB=10, aluOp=11.
  - Go to ALUWB.
- ALUWB: regWrite=1, regSrc=00. Go to FETCH.
- BRANCH: aluSrcA=1, aluSrcB=00, aluOp=01, branch=1, pcSource=1. Go to FETCH.
- JAL: pcWrite=1, pcSource=1, regWrite=1, regSrc=10. Go to FETCH.
- Wait counter (FETCH, MEMRD, MEMWR only):
  - Increments each cycle memReady=0; clears on any state change.
  - If MEM_TIMEOUT>0 and the count reaches MEM_TIMEOUT-1 with memReady=0, the next state is FAULT.
- FAULT: all strobes 0, fault=1. Left only by reset.
- instret: +1 on the edge leaving MEMWB, MEMWR (completed), ALUWB, BRANCH or JAL. Wraps modulo 2^CNT_W.

## Timing
- Reset:
  - On the reset edge: state=FETCH, wait counter=0, instret=0, fault=0.
  - While reset=1, every strobe output is forced to 0.
- Latency with memReady tied high:
  - load: 5 cycles
  - store: 4 cycles
  - R-type and I-type: 4 cycles
  - branch: 3 cycles
  - JAL: 3 cycles
  - illegal opcode: 2 cycles
- Each memory state adds one cycle per memReady=0 cycle.
- memReady is sampled only in FETCH, MEMRD and MEMWR and ignored elsewhere.
- Memory-to-controller handshake is combinational: irWrite and pcWrite in FETCH follow memReady in the same cycle.
- Reset asserted mid-instruction, including in a wait state or FAULT: the FSM returns to FETCH next edge, and no write strobe is issued in the reset cycle.
- Timeout and memReady in the same cycle: memReady wins and the transfer completes.

## Test plan
- memReady=1, sequence lw, sw, add, addi, beq, jal:
  - state traces 0-1-2-3-4, 0-1-2-5, 0-1-6-7, 0-1-6-7, 0-1-8, 0-1-9.
  - instret=6 after 23 cycles.
- lw with memReady low for 3 cycles in MEMRD:
  - memRead=iOrD=1 held for 4 cycles.
  - regWrite pulses once, in MEMWB.
- MEM_TIMEOUT=4, memReady=0 in FETCH:
  - FAULT entered after 4 cycles, fault=1, strobes 0.
  - reset returns state to 0 and fault to 0.
- Opcode 1110011; then IMM_EN=0 with 0010011:
  - illegal pulses 1 cycle in DECODE, back to FETCH, instret unchanged.
- Reset asserted in MEMWR with memReady=1:
  - memWrite=0 that cycle, state=0 next edge, instret=0.
- CNT_W=4, 17 add instructions:
  - instret wraps to 1.

Source files
------------

// File: rtl/control_multiciclo.sv
// Multicycle main control FSM for the RISC-V core: sequences each instruction
// over 3-5 states, with memReady wait states, a memory timeout fault and an instret counter.
module control_multiciclo #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter bit          IMM_EN      = 1'b1,
    parameter bit          JAL_EN      = 1'b1,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       instruc,
    input  logic             memReady,
    output logic             pcWrite,
    output logic             branch,
    output logic             irWrite,
    output logic             memRead,
    output logic             memWrite,
    output logic             iOrD,
    output logic             regWrite,
    output logic             aluSrcA,
    output logic [1:0]       aluSrcB,
    output logic [1:0]       aluOp,
    output logic [1:0]       regSrc,
    output logic             pcSource,
    output logic             illegal,
    output logic             fault,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instret
);

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRType  = 7'b0110011;
    localparam logic [6:0] OpIType  = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;

    // Wide enough to hold MEM_TIMEOUT-1, the last count before faulting.
    localparam int unsigned WaitW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExec   = 4'd6,
        StAluWb  = 4'd7,
        StBranch = 4'd8,
        StJal    = 4'd9,
        StFault  = 4'd15
    } state_t;

    state_t           state_q, state_d;
    state_t           dec_next;
    logic             dec_legal;
    logic [WaitW-1:0] wait_q;
    logic [CNT_W-1:0] instret_q;
    logic             mem_wait, timeout, retire;

    assign mem_wait = (state_q == StFetch || state_q == StMemRd || state_q == StMemWr)
                      && !memReady;
    assign timeout  = (MEM_TIMEOUT != 0) && mem_wait
                      && (wait_q == WaitW'(MEM_TIMEOUT - 1));
    assign retire   = (state_q == StMemWb) || (state_q == StAluWb) || (state_q == StBranch)
                      || (state_q == StJal) || (state_q == StMemWr && memReady);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StFetch;
            wait_q    <= '0;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) begin
                wait_q <= '0;
            end else if (mem_wait) begin
                wait_q <= wait_q + WaitW'(1);
            end
            if (retire) begin
                instret_q <= instret_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        dec_legal = 1'b1;
        dec_next  = StFetch;
        case (instruc)
            OpLoad, OpStore: dec_next = StMemAdr;
            OpRType:         dec_next = StExec;
            OpIType: begin
                dec_next  = StExec;
                dec_legal = IMM_EN;
            end
            OpBranch:        dec_next = StBranch;
            OpJal: begin
                dec_next  = StJal;
                dec_legal = JAL_EN;
            end
            default:         dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch: begin
                if (memReady)     state_d = StDecode;
                else if (timeout) state_d = StFault;
            end
            StDecode: state_d = dec_legal ? dec_next : StFetch;
            StMemAdr: state_d = (instruc == OpLoad) ? StMemRd : StMemWr;
            StMemRd: begin
                if (memReady)     state_d = StMemWb;
                else if (timeout) state_d = StFault;
            end
            StMemWb:  state_d = StFetch;
            StMemWr: begin
                if (memReady)     state_d = StFetch;
                else if (timeout) state_d = StFault;
            end
            StExec:   state_d = StAluWb;
            StAluWb:  state_d = StFetch;
            StBranch: state_d = StFetch;
            StJal:    state_d = StFetch;
            StFault:  state_d = StFault;
            default:  state_d = StFetch;
        endcase
    end

    always_comb begin
        pcWrite  = 1'b0;
        branch   = 1'b0;
        irWrite  = 1'b0;
        memRead  = 1'b0;
        memWrite = 1'b0;
        iOrD     = 1'b0;
        regWrite = 1'b0;
        aluSrcA  = 1'b0;
        aluSrcB  = 2'b00;
        aluOp    = 2'b00;
        regSrc   = 2'b00;
        pcSource = 1'b0;
        illegal  = 1'b0;
        if (!reset) begin
            case (state_q)
                StFetch: begin
                    memRead = 1'b1;
                    aluSrcB = 2'b01;
                    irWrite = memReady;
                    pcWrite = memReady;
                end
                StDecode: begin
                    aluSrcB = 2'b10;
                    illegal = !dec_legal;
                end
                StMemAdr: begin
                    aluSrcA = 1'b1;
                    aluSrcB = 2'b10;
                end
                StMemRd: begin
                    memRead = 1'b1;
                    iOrD    = 1'b1;
                end
                StMemWb: begin
                    regWrite = 1'b1;
                    regSrc   = 2'b01;
                end
                StMemWr: begin
                    memWrite = 1'b1;
                    iOrD     = 1'b1;
                end
                StExec: begin
                    aluSrcA = 1'b1;
                    if (instruc == OpRType) begin
                        aluSrcB = 2'b00;
                        aluOp   = 2'b10;
                    end else begin
                        aluSrcB = 2'b10;
                        aluOp   = 2'b11;
                    end
                end
                StAluWb:  regWrite = 1'b1;
                StBranch: begin
                    aluSrcA  = 1'b1;
                    aluOp    = 2'b01;
                    branch   = 1'b1;
                    pcSource = 1'b1;
                end
                StJal: begin
                    pcWrite  = 1'b1;
                    pcSource = 1'b1;
                    regWrite = 1'b1;
                    regSrc   = 2'b10;
                end
                default: ;
            endcase
        end
    end

    assign fault   = (state_q == StFault);
    assign state   = state_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_control_multiciclo.sv
// Self-checking bench for control_multiciclo: a default instance and a small-parameter
// instance (timeout 4, no I-type/JAL, 4-bit counter) checked against an instruction-level model.
module tb_control_multiciclo;

    localparam logic [6:0] LW   = 7'b0000011;
    localparam logic [6:0] SW   = 7'b0100011;
    localparam logic [6:0] ADD  = 7'b0110011;
    localparam logic [6:0] ADDI = 7'b0010011;
    localparam logic [6:0] BEQ  = 7'b1100011;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] SYS  = 7'b1110011;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_a = 1'b1, reset_b = 1'b1;
    logic        rdy_a = 1'b0, rdy_b = 1'b0;
    logic [6:0]  op_a = 7'd0, op_b = 7'd0;
    logic [16:0] vec_a, vec_b;
    logic [3:0]  state_a, state_b;
    logic [31:0] instret_a;
    logic [3:0]  instret_b;

    int          compared = 0;
    int          mismatched = 0;
    int unsigned cnt [2] = '{0, 0};

    control_multiciclo dut_a (
        .clk(clk), .reset(reset_a), .instruc(op_a), .memReady(rdy_a),
        .pcWrite(vec_a[16]), .branch(vec_a[15]), .irWrite(vec_a[14]), .memRead(vec_a[13]),
        .memWrite(vec_a[12]), .iOrD(vec_a[11]), .regWrite(vec_a[10]), .aluSrcA(vec_a[9]),
        .aluSrcB(vec_a[8:7]), .aluOp(vec_a[6:5]), .regSrc(vec_a[4:3]), .pcSource(vec_a[2]),
        .illegal(vec_a[1]), .fault(vec_a[0]), .state(state_a), .instret(instret_a)
    );

    control_multiciclo #(
        .MEM_TIMEOUT(4), .IMM_EN(1'b0), .JAL_EN(1'b0), .CNT_W(4)
    ) dut_b (
        .clk(clk), .reset(reset_b), .instruc(op_b), .memReady(rdy_b),
        .pcWrite(vec_b[16]), .branch(vec_b[15]), .irWrite(vec_b[14]), .memRead(vec_b[13]),
        .memWrite(vec_b[12]), .iOrD(vec_b[11]), .regWrite(vec_b[10]), .aluSrcA(vec_b[9]),
        .aluSrcB(vec_b[8:7]), .aluOp(vec_b[6:5]), .regSrc(vec_b[4:3]), .pcSource(vec_b[2]),
        .illegal(vec_b[1]), .fault(vec_b[0]), .state(state_b), .instret(instret_b)
    );

    // 0 load, 1 store, 2 R-type, 3 I-type, 4 branch, 5 jal, 6 illegal
    function automatic int classify(input logic [6:0] op, input int w);
        case (op)
            LW:      return 0;
            SW:      return 1;
            ADD:     return 2;
            ADDI:    return (w == 0) ? 3 : 6;
            BEQ:     return 4;
            JAL:     return (w == 0) ? 5 : 6;
            default: return 6;
        endcase
    endfunction

    // Output table per state: {pcWrite,branch,irWrite,memRead,memWrite,iOrD,regWrite,
    // aluSrcA,aluSrcB[2],aluOp[2],regSrc[2],pcSource,illegal,fault}
    function automatic logic [16:0] exp_vec(input logic [3:0] st, input logic rdy,
                                            input logic [6:0] op, input logic rst, input int w);
        logic [16:0] v;
        int c;
        v = '0;
        c = classify(op, w);
        v[0] = (st == 4'd15);
        if (rst) return v;
        case (st)
            4'd0: begin v[13] = 1'b1; v[8:7] = 2'b01; v[14] = rdy; v[16] = rdy; end
            4'd1: begin v[8:7] = 2'b10; v[1] = (c == 6); end
            4'd2: begin v[9] = 1'b1; v[8:7] = 2'b10; end
            4'd3: begin v[13] = 1'b1; v[11] = 1'b1; end
            4'd4: begin v[10] = 1'b1; v[4:3] = 2'b01; end
            4'd5: begin v[12] = 1'b1; v[11] = 1'b1; end
            4'd6: begin
                v[9] = 1'b1;
                if (c == 2) v[6:5] = 2'b10;
                else begin v[8:7] = 2'b10; v[6:5] = 2'b11; end
            end
            4'd7: v[10] = 1'b1;
            4'd8: begin v[9] = 1'b1; v[6:5] = 2'b01; v[15] = 1'b1; v[2] = 1'b1; end
            4'd9: begin v[16] = 1'b1; v[2] = 1'b1; v[10] = 1'b1; v[4:3] = 2'b10; end
            default: ;
        endcase
        return v;
    endfunction

    task automatic cycle_check(input int w, input logic rst, input logic rdy,
                               input logic [6:0] op, input logic [3:0] st, input string tag);
        logic [3:0]  obs_st;
        logic [16:0] obs_v, ev;
        logic [31:0] obs_c, exp_c;
        @(negedge clk);
        if (w == 0) begin reset_a = rst; rdy_a = rdy; op_a = op; end
        else        begin reset_b = rst; rdy_b = rdy; op_b = op; end
        #1;
        obs_st = (w == 0) ? state_a : state_b;
        obs_v  = (w == 0) ? vec_a : vec_b;
        obs_c  = (w == 0) ? instret_a : {28'd0, instret_b};
        exp_c  = (w == 0) ? cnt[0] : (cnt[1] & 32'hF);
        ev     = exp_vec(st, rdy, op, rst, w);
        compared += 3;
        assert (obs_st === st) else begin
            mismatched++;
            $error("FAIL %s/dut%0d state: got %0d want %0d", tag, w, obs_st, st);
        end
        assert (obs_v === ev) else begin
            mismatched++;
            $error("FAIL %s/dut%0d outputs: got %b want %b (state %0d)", tag, w, obs_v, ev, st);
        end
        assert (obs_c === exp_c) else begin
            mismatched++;
            $error("FAIL %s/dut%0d instret: got %0d want %0d", tag, w, obs_c, exp_c);
        end
        if (rst) cnt[w] = 0;
    endtask

    // Runs one instruction from FETCH with fw fetch waits and mw waits in MEMRD/MEMWR.
    task automatic run_instr(input int w, input logic [6:0] op, input int fw, input int mw,
                             input string tag);
        int c;
        int q[$];
        c = classify(op, w);
        for (int i = 0; i < fw; i++) cycle_check(w, 1'b0, 1'b0, op, 4'd0, tag);
        cycle_check(w, 1'b0, 1'b1, op, 4'd0, tag);
        cycle_check(w, 1'b0, 1'($urandom_range(0, 1)), op, 4'd1, tag);
        case (c)
            0: begin q.push_back(2); q.push_back(3); q.push_back(4); end
            1: begin q.push_back(2); q.push_back(5); end
            2, 3: begin q.push_back(6); q.push_back(7); end
            4: q.push_back(8);
            5: q.push_back(9);
            default: ;
        endcase
        foreach (q[i]) begin
            if (q[i] == 3 || q[i] == 5) begin
                for (int j = 0; j < mw; j++) cycle_check(w, 1'b0, 1'b0, op, 4'(q[i]), tag);
                cycle_check(w, 1'b0, 1'b1, op, 4'(q[i]), tag);
            end else begin
                cycle_check(w, 1'b0, 1'($urandom_range(0, 1)), op, 4'(q[i]), tag);
            end
        end
        if (c != 6) cnt[w]++;
    endtask

    logic [6:0] ops [8] = '{LW, SW, ADD, ADDI, BEQ, JAL, SYS, 7'b0000000};

    initial begin
        // Reset state, then the directed all-ready sequence (23 cycles, instret ends at 6)
        cycle_check(0, 1'b1, 1'b1, 7'd0, 4'd0, "reset");
        cycle_check(0, 1'b1, 1'b0, LW, 4'd0, "reset");
        run_instr(0, LW,   0, 0, "seq_lw");
        run_instr(0, SW,   0, 0, "seq_sw");
        run_instr(0, ADD,  0, 0, "seq_add");
        run_instr(0, ADDI, 0, 0, "seq_addi");
        run_instr(0, BEQ,  0, 0, "seq_beq");
        run_instr(0, JAL,  0, 0, "seq_jal");
        run_instr(0, LW,   0, 3, "lw_wait3");
        run_instr(0, SYS,  0, 0, "illegal");
        run_instr(0, SW,   2, 2, "sw_wait");

        for (int k = 0; k < 40; k++)
            run_instr(0, ops[$urandom_range(0, 7)], $urandom_range(0, 4), $urandom_range(0, 4),
                      "random");

        // Reset during MEMWR with memReady high: the store must not complete
        cycle_check(0, 1'b0, 1'b1, SW, 4'd0, "rst_memwr");
        cycle_check(0, 1'b0, 1'b1, SW, 4'd1, "rst_memwr");
        cycle_check(0, 1'b0, 1'b1, SW, 4'd2, "rst_memwr");
        cycle_check(0, 1'b1, 1'b1, SW, 4'd5, "rst_memwr");
        run_instr(0, ADD, 0, 0, "after_rst");

        // Small-parameter instance: fetch timeout into FAULT and recovery by reset
        cycle_check(1, 1'b1, 1'b0, ADD, 4'd0, "b_reset");
        for (int i = 0; i < 4; i++) cycle_check(1, 1'b0, 1'b0, ADD, 4'd0, "b_timeout");
        cycle_check(1, 1'b0, 1'b0, ADD, 4'd15, "b_fault");
        cycle_check(1, 1'b0, 1'b1, ADD, 4'd15, "b_fault");
        cycle_check(1, 1'b1, 1'b0, ADD, 4'd15, "b_fault_rst");
        // memReady on the timeout cycle wins
        run_instr(1, ADD, 3, 0, "b_edge");
        run_instr(1, ADDI, 0, 0, "b_no_imm");
        run_instr(1, JAL, 1, 0, "b_no_jal");
        run_instr(1, SW, 0, 3, "b_sw_edge");

        // Timeout while waiting in MEMWR
        cycle_check(1, 1'b0, 1'b1, SW, 4'd0, "b_wr_to");
        cycle_check(1, 1'b0, 1'b0, SW, 4'd1, "b_wr_to");
        cycle_check(1, 1'b0, 1'b0, SW, 4'd2, "b_wr_to");
        for (int i = 0; i < 4; i++) cycle_check(1, 1'b0, 1'b0, SW, 4'd5, "b_wr_to");
        cycle_check(1, 1'b0, 1'b0, SW, 4'd15, "b_wr_to");
        cycle_check(1, 1'b1, 1'b0, SW, 4'd15, "b_wr_rst");

        // 17 adds on a 4-bit counter wrap to 1
        for (int k = 0; k < 17; k++)
            run_instr(1, ADD, $urandom_range(0, 2), 0, "b_wrap");
        cycle_check(1, 1'b0, 1'b0, ADD, 4'd0, "b_wrap_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
